// File: rtl/encoder_pkg.sv
// Shared types and constants for the stego encoder burst scheduler.
// Holds the state encoding, requester slot indices and AXI page geometry.
package encoder_pkg;

    typedef enum logic [2:0] {
        SCHED_IDLE  = 3'd0,
        SCHED_GRANT = 3'd1,
        SCHED_ISSUE = 3'd2,
        SCHED_WAIT  = 3'd3,
        SCHED_DONE  = 3'd4
    } sched_state_e;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_GRANT = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam int REQ_CIMG    = 0;
    localparam int REQ_SIMG    = 1;
    localparam int REQ_MSG     = 2;
    localparam int REQ_SIMG_WR = 3;

    localparam int PAGE_BYTES = 4096;
    localparam int BEAT_BYTES = 4;

    function automatic logic [15:0] min3(input logic [15:0] a,
                                         input logic [15:0] b,
                                         input logic [15:0] c);
        logic [15:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

endpackage

// File: rtl/encoder_burst_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one slot past the
// previous winner and wraps, so every active requester is eventually served.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               gnt_valid,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic [IDX_W:0] cand;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_grant} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!gnt_valid && req[cand[IDX_W-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/encoder_burst_sched.sv
// Splits each requester's transfer into AXI bursts that never cross a 4 KB
// page, keeping exactly one burst command outstanding at a time.
module encoder_burst_sched
    import encoder_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BEATS = 128,
    parameter int ADDR_W    = 32
) (
    input  logic                             axi_clk,
    input  logic                             axi_resetn,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ-1:0][15:0]         req_beats,
    input  logic [NUM_REQ-1:0]               req_write,
    output logic [NUM_REQ-1:0]               req_done,
    output logic                             cmd_valid,
    input  logic                             cmd_ready,
    output logic [ADDR_W-1:0]                cmd_addr,
    output logic [7:0]                       cmd_len,
    output logic                             cmd_write,
    output logic [1:0]                       cmd_id,
    input  logic                             burst_done,
    input  logic                             burst_err,
    output logic                             sched_busy,
    output logic                             sched_error,
    output sched_state_e                     dbg_state
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [2:0]        state_q;
    logic [IDX_W-1:0]  last_grant_q;
    logic [IDX_W-1:0]  id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       remain_q;
    logic              write_q;
    logic              error_q;

    logic              gnt_valid;
    logic [IDX_W-1:0]  gnt_idx;
    logic [15:0]       page_beats;
    logic [15:0]       size_w;
    logic              issuing;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx)
    );

    // Beats left before the next 4 KB page boundary; addr_q is word aligned.
    assign page_beats = 16'(PAGE_BYTES / BEAT_BYTES) - 16'(addr_q[11:2]);
    assign size_w     = min3(remain_q, 16'(MAX_BEATS), page_beats);

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            id_q         <= '0;
            addr_q       <= '0;
            remain_q     <= '0;
            write_q      <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|req_valid) state_q <= ST_GRANT;
                end
                ST_GRANT: begin
                    if (gnt_valid) begin
                        id_q     <= gnt_idx;
                        addr_q   <= {req_addr[gnt_idx][ADDR_W-1:2], 2'b00};
                        remain_q <= req_beats[gnt_idx];
                        write_q  <= req_write[gnt_idx];
                        state_q  <= (req_beats[gnt_idx] == 16'd0) ? ST_DONE : ST_ISSUE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (cmd_ready) state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (burst_done) begin
                        addr_q   <= addr_q + ADDR_W'({size_w, 2'b00});
                        remain_q <= remain_q - size_w;
                        if (burst_err) begin
                            error_q <= 1'b1;
                            state_q <= ST_DONE;
                        end else if (remain_q == size_w) begin
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
                    last_grant_q <= id_q;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // cmd_valid is held with cmd_* stable until the cycle cmd_ready is seen
    // high on a rising edge; that edge is the handshake. req_ready and
    // req_done are single-cycle pulses, not handshakes.
    assign issuing     = (state_q == ST_ISSUE);
    assign cmd_valid   = issuing;
    assign cmd_addr    = issuing ? addr_q : '0;
    assign cmd_len     = issuing ? 8'(size_w - 16'd1) : 8'd0;
    assign cmd_write   = issuing & write_q;
    assign cmd_id      = issuing ? 2'(id_q) : 2'd0;

    assign req_ready   = (state_q == ST_GRANT && gnt_valid) ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign req_done    = (state_q == ST_DONE) ? (NUM_REQ'(1) << id_q) : '0;
    assign sched_busy  = (state_q != ST_IDLE);
    assign sched_error = error_q;
    assign dbg_state   = sched_state_e'(state_q);

endmodule

// File: tb/tb_encoder_burst_sched.sv
// Directed bench for encoder_burst_sched: a hand-driven burst engine with
// hand-computed command sequences for each transfer scenario.
module tb_encoder_burst_sched;
    import encoder_pkg::*;

    logic                  axi_clk = 1'b0;
    logic                  axi_resetn;
    logic [3:0]            req_valid;
    logic [3:0]            req_ready;
    logic [3:0][31:0]      req_addr;
    logic [3:0][15:0]      req_beats;
    logic [3:0]            req_write;
    logic [3:0]            req_done;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [31:0]           cmd_addr;
    logic [7:0]            cmd_len;
    logic                  cmd_write;
    logic [1:0]            cmd_id;
    logic                  burst_done;
    logic                  burst_err;
    logic                  sched_busy;
    logic                  sched_error;
    sched_state_e          dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    int cmd_cnt  = 0;
    int ready_cnt [4] = '{0, 0, 0, 0};
    int done_cnt  [4] = '{0, 0, 0, 0};
    int snap_cmd;
    int snap_rdy  [4];
    int snap_done;

    encoder_burst_sched #(
        .NUM_REQ   (4),
        .MAX_BEATS (128),
        .ADDR_W    (32)
    ) dut (
        .axi_clk     (axi_clk),
        .axi_resetn  (axi_resetn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_beats   (req_beats),
        .req_write   (req_write),
        .req_done    (req_done),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .cmd_write   (cmd_write),
        .cmd_id      (cmd_id),
        .burst_done  (burst_done),
        .burst_err   (burst_err),
        .sched_busy  (sched_busy),
        .sched_error (sched_error),
        .dbg_state   (dbg_state)
    );

    always #5 axi_clk = ~axi_clk;

    always @(negedge axi_clk) begin
        if (cmd_valid) cmd_cnt++;
        for (int i = 0; i < 4; i++) begin
            if (req_ready[i]) ready_cnt[i]++;
            if (req_done[i])  done_cnt[i]++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic wait_ready(input string tag, input int id);
        int n;
        n = 0;
        while (req_ready == 4'd0 && n < 10) begin
            step();
            n++;
        end
        chk({tag, "_ready"}, 64'(req_ready), 64'(1) << id);
    endtask

    task automatic expect_cmd(input string tag, input logic [31:0] addr, input logic [7:0] len,
                              input logic wr, input logic [1:0] id, input int stall);
        int n;
        n = 0;
        while (!cmd_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, 64'(cmd_valid), 64'd1);
        chk({tag, "_addr"},  64'(cmd_addr),  64'(addr));
        chk({tag, "_len"},   64'(cmd_len),   64'(len));
        chk({tag, "_write"}, 64'(cmd_write), 64'(wr));
        chk({tag, "_id"},    64'(cmd_id),    64'(id));
        for (int s = 0; s < stall; s++) begin
            step();
            chk({tag, "_hold"}, 64'({cmd_valid, cmd_addr, cmd_len}), 64'({1'b1, addr, len}));
        end
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        chk({tag, "_wait_nocmd"}, 64'(cmd_valid), 64'd0);
    endtask

    task automatic finish_burst(input logic err);
        burst_done = 1'b1;
        burst_err  = err;
        step();
        burst_done = 1'b0;
        burst_err  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int id);
        int n;
        n = 0;
        while (req_done == 4'd0 && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_done"}, 64'(req_done), 64'(1) << id);
        step();
        chk({tag, "_done_1cyc"}, 64'({req_done, sched_busy}), 64'd0);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({req_ready, req_done, cmd_valid, cmd_addr, cmd_len, cmd_write,
                    cmd_id, sched_busy, sched_error});
    endfunction

    initial begin
        axi_resetn = 1'b0;
        req_valid  = '0;
        req_addr   = '0;
        req_beats  = '0;
        req_write  = '0;
        cmd_ready  = 1'b0;
        burst_done = 1'b0;
        burst_err  = 1'b0;
        repeat (3) step();
        chk("reset_outs", all_outs(), 64'd0);
        chk("reset_state", 64'(dbg_state), 64'(ST_IDLE));
        axi_resetn = 1'b1;
        step();

        // stray burst_done in IDLE must be ignored
        finish_burst(1'b1);
        chk("idle_ignore_done", 64'({dbg_state, req_done, sched_error}), 64'({ST_IDLE, 4'd0, 1'b0}));

        // single 64-beat read on requester 0, checking the 1/2 cycle latency
        req_addr[0]  = 32'h0000_0000;
        req_beats[0] = 16'd64;
        req_valid    = 4'b0001;
        step();
        chk("t1_ready_lat", 64'(req_ready), 64'h1);
        chk("t1_no_cmd_in_grant", 64'(cmd_valid), 64'd0);
        step();
        req_valid = 4'b0000;
        chk("t1_cmd_lat", 64'(cmd_valid), 64'd1);
        expect_cmd("t1_c0", 32'h0, 8'd63, 1'b0, 2'd0, 0);
        chk("t1_busy_wait", 64'(sched_busy), 64'd1);
        finish_burst(1'b0);
        wait_done("t1", 0);

        // 0xF00 / 200 beats: page split then MAX_BEATS split
        snap_done    = done_cnt[1];
        req_addr[1]  = 32'h0000_0F00;
        req_beats[1] = 16'd200;
        req_valid    = 4'b0010;
        wait_ready("t2", 1);
        step();
        req_valid = 4'b0000;
        expect_cmd("t2_c0", 32'h0F00, 8'd63, 1'b0, 2'd1, 2);
        finish_burst(1'b0);
        expect_cmd("t2_c1", 32'h1000, 8'd127, 1'b0, 2'd1, 0);
        finish_burst(1'b0);
        expect_cmd("t2_c2", 32'h1200, 8'd7, 1'b0, 2'd1, 0);
        finish_burst(1'b0);
        wait_done("t2", 1);
        chk("t2_one_done", 64'(done_cnt[1] - snap_done), 64'd1);

        // all four valid straight out of reset: order 0,1,2,3
        axi_resetn = 1'b0;
        step();
        step();
        axi_resetn = 1'b1;
        step();
        for (int i = 0; i < 4; i++) snap_rdy[i] = ready_cnt[i];
        for (int i = 0; i < 4; i++) begin
            req_addr[i]  = 32'(i) * 32'h100;
            req_beats[i] = 16'd1;
        end
        req_write = 4'b1000;
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_ready("t3", i);
            step();
            req_valid[i] = 1'b0;
            expect_cmd("t3_c", 32'(i) * 32'h100, 8'd0, (i == 3), 2'(i), 0);
            finish_burst(1'b0);
            wait_done("t3", i);
        end
        for (int i = 0; i < 4; i++) chk("t3_ready_once", 64'(ready_cnt[i] - snap_rdy[i]), 64'd1);
        req_write = 4'b0000;

        // error on the first of three bursts aborts the rest
        req_addr[0]  = 32'h0;
        req_beats[0] = 16'd300;
        req_valid    = 4'b0001;
        wait_ready("t4", 0);
        step();
        req_valid = 4'b0000;
        expect_cmd("t4_c0", 32'h0, 8'd127, 1'b0, 2'd0, 0);
        snap_cmd = cmd_cnt;
        finish_burst(1'b1);
        wait_done("t4", 0);
        repeat (5) step();
        chk("t4_no_more_cmds", 64'(cmd_cnt - snap_cmd), 64'd0);
        chk("t4_error_sticky", 64'(sched_error), 64'd1);

        // zero-beat request completes without a command
        snap_cmd     = cmd_cnt;
        req_addr[2]  = 32'h40;
        req_beats[2] = 16'd0;
        req_valid    = 4'b0100;
        wait_ready("t5", 2);
        step();
        req_valid = 4'b0000;
        chk("t5_done_next", 64'(req_done), 64'h4);
        step();
        chk("t5_idle", 64'(dbg_state), 64'(ST_IDLE));
        chk("t5_no_cmd", 64'(cmd_cnt - snap_cmd), 64'd0);

        // reset while a burst is outstanding
        req_addr[1]  = 32'h0;
        req_beats[1] = 16'd16;
        req_valid    = 4'b0010;
        wait_ready("t6", 1);
        step();
        req_valid = 4'b0000;
        expect_cmd("t6_c0", 32'h0, 8'd15, 1'b0, 2'd1, 0);
        chk("t6_in_wait", 64'(dbg_state), 64'(ST_WAIT));
        snap_done = done_cnt[1];
        #1;
        axi_resetn = 1'b0;
        #1;
        chk("t6_async_outs", all_outs(), 64'd0);
        step();
        step();
        axi_resetn = 1'b1;
        repeat (3) step();
        chk("t6_no_done", 64'(done_cnt[1] - snap_done), 64'd0);
        req_addr[1]  = 32'h2000;
        req_beats[1] = 16'd4;
        req_valid    = 4'b0010;
        wait_ready("t6b", 1);
        step();
        req_valid = 4'b0000;
        expect_cmd("t6b_c0", 32'h2000, 8'd3, 1'b0, 2'd1, 0);
        finish_burst(1'b0);
        wait_done("t6b", 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
